// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared collector/feeder types and default array dimensions
package fifo_pkg;

   localparam int DEFAULT_DEPTH = 8;
   localparam int DEFAULT_BITS  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SKIP    = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } collect_state_t;

endpackage

// File: rtl/fifo_collect.sv
// rtl/fifo_collect.sv - drops column skew, gathers DEPTH serial samples into a parallel vector
import fifo_pkg::*;

module fifo_collect #(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int BITS   = DEFAULT_BITS,
   parameter int SKEW_W = $clog2(2*DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [SKEW_W-1:0]      skew,
   input  logic                   en,
   input  logic signed [BITS-1:0] d,
   input  logic                   rd,
   output logic signed [BITS-1:0] q [DEPTH],
   output logic                   valid,
   output logic                   busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   collect_state_t    state;
   logic [SKEW_W-1:0] skip_cnt;
   logic [IDX_W-1:0]  idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         valid    <= 1'b0;
         skip_cnt <= '0;
         idx      <= '0;
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else if (start) begin
         // restart wins over en/rd; this cycle's d is never used
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         idx      <= '0;
         valid    <= 1'b0;
         skip_cnt <= skew;
         state    <= (skew != '0) ? SKIP : CAPTURE;
      end else begin
         case (state)
            SKIP: begin
               if (en) begin
                  skip_cnt <= skip_cnt - SKEW_W'(1);
                  if (skip_cnt == SKEW_W'(1)) state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (en) begin
                  q[idx] <= d;
                  idx    <= idx + IDX_W'(1);
                  if (idx == LAST_IDX) begin
                     state <= DONE;
                     valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (rd) begin
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == SKIP) || (state == CAPTURE);

endmodule

// File: tb/tb_fifo_collect.sv
// tb/tb_fifo_collect.sv - scoreboard bench for fifo_collect
module tb_fifo_collect;

   localparam int DEPTH  = 8;
   localparam int BITS   = 8;
   localparam int SKEW_W = $clog2(2*DEPTH);

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   start;
   logic [SKEW_W-1:0]      skew;
   logic                   en;
   logic signed [BITS-1:0] d;
   logic                   rd;
   logic signed [BITS-1:0] q [DEPTH];
   logic                   valid;
   logic                   busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic signed [BITS-1:0] exp_q [$];
   logic signed [BITS-1:0] exp_vec [DEPTH];

   fifo_collect #(.DEPTH(DEPTH), .BITS(BITS), .SKEW_W(SKEW_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .skew(skew), .en(en),
      .d(d), .rd(rd), .q(q), .valid(valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_q_vec(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++;
         if (q[i] !== exp_vec[i]) begin
            n_fail++;
            $display("FAIL %s q[%0d]: got %0d expected %0d", name, i, q[i], exp_vec[i]);
         end
      end
   endtask

   task automatic check_q_zero(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++;
         if (q[i] !== '0) begin
            n_fail++;
            $display("FAIL %s q[%0d]: got %0d expected 0", name, i, q[i]);
         end
      end
   endtask

   // pops the scoreboard into exp_vec and compares against q
   task automatic check_from_scoreboard(input string name);
      n_cmp++;
      if (exp_q.size() != DEPTH) begin
         n_fail++;
         $display("FAIL %s scoreboard size: got %0d expected %0d", name, exp_q.size(), DEPTH);
      end
      for (int i = 0; i < DEPTH; i++)
         exp_vec[i] = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      exp_q.delete();
      check_q_vec(name);
   endtask

   // start, then feed d=base,base+1,... on enabled cycles until valid
   task automatic run_capture(input int s, input bit stall, input int base, input string name);
      int cycles = 0;
      int m_skip = s;
      int got = 0;
      int val = base;
      int exp_lat = stall ? 2*(s+DEPTH)-1 : s+DEPTH;
      start = 1'b1; skew = SKEW_W'(s); en = 1'b0; rd = 1'b0;
      cyc();
      start = 1'b0;
      check_bit({name, " busy after start"}, busy, 1'b1);
      while (!valid && cycles < 200) begin
         en = stall ? (cycles % 2 == 0) : 1'b1;
         d  = BITS'(val);
         if (en) begin
            if (m_skip > 0) m_skip--;
            else if (got < DEPTH) begin
               exp_q.push_back(BITS'(val));
               got++;
            end
            val++;
         end
         cyc();
         cycles++;
      end
      en = 1'b0;
      n_cmp++;
      if (cycles != exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d", name, cycles, exp_lat);
      end
      check_bit({name, " busy at valid"}, busy, 1'b0);
      check_from_scoreboard(name);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; skew = '0; en = 1'b0; d = '0; rd = 1'b0;
      repeat (2) cyc();
      check_bit("reset valid", valid, 1'b0);
      check_bit("reset busy", busy, 1'b0);
      check_q_zero("reset");
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      run_capture(0, 1'b0, 1, "basic");
   endtask

   task automatic test_skew();
      run_capture(7, 1'b0, -7, "skew");
   endtask

   task automatic test_hold();
      en = 1'b1; d = 8'sh55; rd = 1'b0;
      repeat (5) cyc();
      check_bit("hold valid", valid, 1'b1);
      check_q_vec("hold");
      rd = 1'b1;
      cyc();
      rd = 1'b0; en = 1'b0;
      check_bit("rd valid", valid, 1'b0);
      check_bit("rd busy", busy, 1'b0);
      check_q_vec("rd retained");
      rd = 1'b1; en = 1'b1; d = 8'sh33;
      repeat (2) cyc();
      rd = 1'b0; en = 1'b0;
      check_bit("idle rd valid", valid, 1'b0);
      check_bit("idle en busy", busy, 1'b0);
      check_q_vec("idle ignored");
   endtask

   task automatic test_stall();
      run_capture(2, 1'b1, 1, "stall");
   endtask

   task automatic test_restart();
      int cycles = 0;
      start = 1'b1; skew = '0; cyc();
      start = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = BITS'(10 + i);
         cyc();
      end
      start = 1'b1; skew = SKEW_W'(1); en = 1'b1; d = 8'sh7F;
      cyc();
      start = 1'b0;
      check_q_zero("restart clear");
      check_bit("restart busy", busy, 1'b1);
      check_bit("restart valid", valid, 1'b0);
      d = 8'sd20;
      cyc();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(BITS'(21 + i));
      for (int i = 0; i < DEPTH; i++) begin
         d = BITS'(21 + i);
         cyc();
      end
      en = 1'b0;
      while (!valid && cycles < 20) begin
         cyc();
         cycles++;
      end
      check_bit("restart done valid", valid, 1'b1);
      check_from_scoreboard("restart");
   endtask

   task automatic test_async_reset();
      run_capture(0, 1'b0, 40, "pre-reset");
      #2 rst_n = 1'b0;
      #1;
      check_bit("async done valid", valid, 1'b0);
      check_q_zero("async done");
      @(negedge clk) rst_n = 1'b1;
      cyc();
      start = 1'b1; skew = SKEW_W'(5); cyc();
      start = 1'b0; en = 1'b1; d = 8'sd9; cyc();
      check_bit("skip busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_bit("async skip busy", busy, 1'b0);
      check_bit("async skip valid", valid, 1'b0);
      check_q_zero("async skip");
      en = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skew();
      test_hold();
      test_stall();
      rd = 1'b1; cyc(); rd = 1'b0;
      test_restart();
      rd = 1'b1; cyc(); rd = 1'b0;
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
